// File: rtl/c7bbiu_axi_sram_slave.sv
// AXI responder backed by a 64-bit register-array SRAM; independent read and write FSMs.
// Optional SLVERR reporting for out-of-window beats is enabled by C7BBIU_AXI_SLV_ERR_EN.
module c7bbiu_axi_sram_slave #(
    parameter int unsigned MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        biu_ext_ar_valid,
    output logic        ext_biu_ar_ready,
    input  logic [3:0]  biu_ext_ar_id,
    input  logic [31:0] biu_ext_ar_addr,
    input  logic [7:0]  biu_ext_ar_len,
    output logic        ext_biu_r_valid,
    input  logic        biu_ext_r_ready,
    output logic [3:0]  ext_biu_r_id,
    output logic [63:0] ext_biu_r_data,
    output logic [1:0]  ext_biu_r_resp,
    output logic        ext_biu_r_last,
    input  logic        biu_ext_aw_valid,
    output logic        ext_biu_aw_ready,
    input  logic [3:0]  biu_ext_aw_id,
    input  logic [31:0] biu_ext_aw_addr,
    input  logic [7:0]  biu_ext_aw_len,
    input  logic        biu_ext_w_valid,
    output logic        ext_biu_w_ready,
    input  logic [63:0] biu_ext_w_data,
    input  logic [7:0]  biu_ext_w_strb,
    input  logic        biu_ext_w_last,
    output logic        ext_biu_b_valid,
    input  logic        biu_ext_b_ready,
    output logic [3:0]  ext_biu_b_id,
    output logic [1:0]  ext_biu_b_resp
);
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam int unsigned WOFS_W    = 30;

    typedef enum logic       {RD_IDLE, RD_BURST} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    logic [63:0] r_mem [MEM_DEPTH];

    rd_state_t         r_rd_state, w_rd_state_nxt;
    logic [WOFS_W-1:0] r_rd_wofs, w_rd_wofs_nxt;
    logic [7:0]        r_rd_cnt, w_rd_cnt_nxt, r_rd_len, w_rd_len_nxt;
    logic              w_rd_load, w_rd_oob, w_ar_hs;
    logic [MEM_AW-1:0] w_rd_idx;
    logic [31:0]       w_ar_ofs;
    logic              r_ar_ready, r_r_valid, r_r_last;
    logic [3:0]        r_r_id;
    logic [63:0]       r_r_data;
    logic [1:0]        r_r_resp;

    wr_state_t         r_wr_state, w_wr_state_nxt;
    logic [WOFS_W-1:0] r_wr_wofs, w_wr_wofs_nxt;
    logic [7:0]        r_wr_cnt, w_wr_cnt_nxt, r_wr_len, w_wr_len_nxt;
    logic              r_wr_err, w_wr_err_nxt, w_mem_we, w_aw_hs, w_wr_done;
    logic              w_wr_beat_oob, w_wr_beat_bad;
    logic [MEM_AW-1:0] w_wr_idx;
    logic [31:0]       w_aw_ofs;
    logic              r_aw_ready, r_w_ready, r_b_valid;
    logic [3:0]        r_b_id;
    logic [1:0]        r_b_resp;
    logic              w_unused;

    // Word offsets keep bits above MEM_AW so out-of-window beats stay detectable.
    assign w_ar_ofs  = biu_ext_ar_addr - BASE_ADDR;
    assign w_aw_ofs  = biu_ext_aw_addr - BASE_ADDR;
    assign w_ar_hs   = r_ar_ready & biu_ext_ar_valid;
    assign w_aw_hs   = r_aw_ready & biu_ext_aw_valid;
    assign w_rd_idx  = w_rd_wofs_nxt[MEM_AW-1:0];
    assign w_wr_idx  = r_wr_wofs[MEM_AW-1:0];
    assign w_wr_done = (r_wr_cnt == r_wr_len);
    assign w_unused  = ^{biu_ext_w_last, w_ar_ofs[2:0], w_aw_ofs[2:0]};

`ifdef C7BBIU_AXI_SLV_ERR_EN
    assign w_rd_oob      = |w_rd_wofs_nxt[WOFS_W-1:MEM_AW];
    assign w_wr_beat_oob = |r_wr_wofs[WOFS_W-1:MEM_AW];
    assign w_wr_beat_bad = w_wr_beat_oob | (biu_ext_w_last != w_wr_done);
`else
    assign w_rd_oob      = 1'b0;
    assign w_wr_beat_oob = 1'b0;
    assign w_wr_beat_bad = 1'b0;
`endif

    // Read next-state: one beat per cycle, next word loaded on each non-final handshake.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_wofs_nxt  = r_rd_wofs;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_rd_len_nxt   = r_rd_len;
        w_rd_load      = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_nxt = RD_BURST;
                    w_rd_wofs_nxt  = {1'b0, w_ar_ofs[31:3]};
                    w_rd_cnt_nxt   = 8'd0;
                    w_rd_len_nxt   = biu_ext_ar_len;
                    w_rd_load      = 1'b1;
                end
            end
            RD_BURST: begin
                if (biu_ext_r_ready) begin
                    if (r_r_last) begin
                        w_rd_state_nxt = RD_IDLE;
                    end else begin
                        w_rd_cnt_nxt  = r_rd_cnt + 8'd1;
                        w_rd_wofs_nxt = r_rd_wofs + WOFS_W'(1);
                        w_rd_load     = 1'b1;
                    end
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
            r_rd_wofs  <= '0;
            r_rd_cnt   <= '0;
            r_rd_len   <= '0;
            r_ar_ready <= 1'b1;
            r_r_valid  <= 1'b0;
            r_r_id     <= '0;
            r_r_data   <= '0;
            r_r_last   <= 1'b0;
            r_r_resp   <= 2'b00;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_wofs  <= w_rd_wofs_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_rd_len   <= w_rd_len_nxt;
            r_ar_ready <= (w_rd_state_nxt == RD_IDLE);
            r_r_valid  <= (w_rd_state_nxt == RD_BURST);
            if (w_ar_hs) begin
                r_r_id <= biu_ext_ar_id;
            end
            if (w_rd_load) begin
                r_r_data <= w_rd_oob ? 64'd0 : r_mem[w_rd_idx];
                r_r_last <= (w_rd_cnt_nxt == w_rd_len_nxt);
                r_r_resp <= w_rd_oob ? 2'b10 : 2'b00;
            end else if (w_rd_state_nxt == RD_IDLE) begin
                r_r_last <= 1'b0;
                r_r_resp <= 2'b00;
            end
        end
    end

    // Write next-state: burst length comes from AW len, never from w_last.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_wofs_nxt  = r_wr_wofs;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_wr_len_nxt   = r_wr_len;
        w_wr_err_nxt   = r_wr_err;
        w_mem_we       = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_aw_hs) begin
                    w_wr_state_nxt = WR_DATA;
                    w_wr_wofs_nxt  = {1'b0, w_aw_ofs[31:3]};
                    w_wr_cnt_nxt   = 8'd0;
                    w_wr_len_nxt   = biu_ext_aw_len;
                    w_wr_err_nxt   = 1'b0;
                end
            end
            WR_DATA: begin
                if (biu_ext_w_valid) begin
                    w_mem_we     = ~w_wr_beat_oob;
                    w_wr_err_nxt = r_wr_err | w_wr_beat_bad;
                    if (w_wr_done) begin
                        w_wr_state_nxt = WR_RESP;
                    end else begin
                        w_wr_cnt_nxt  = r_wr_cnt + 8'd1;
                        w_wr_wofs_nxt = r_wr_wofs + WOFS_W'(1);
                    end
                end
            end
            WR_RESP: begin
                if (biu_ext_b_ready) begin
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
            r_wr_wofs  <= '0;
            r_wr_cnt   <= '0;
            r_wr_len   <= '0;
            r_wr_err   <= 1'b0;
            r_aw_ready <= 1'b1;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_id     <= '0;
            r_b_resp   <= 2'b00;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_wofs  <= w_wr_wofs_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_wr_len   <= w_wr_len_nxt;
            r_wr_err   <= w_wr_err_nxt;
            r_aw_ready <= (w_wr_state_nxt == WR_IDLE);
            r_w_ready  <= (w_wr_state_nxt == WR_DATA);
            r_b_valid  <= (w_wr_state_nxt == WR_RESP);
            r_b_resp   <= ((w_wr_state_nxt == WR_RESP) && w_wr_err_nxt) ? 2'b10 : 2'b00;
            if (w_aw_hs) begin
                r_b_id <= biu_ext_aw_id;
            end
        end
    end

    // Byte-lane writes; same-cycle read load still sees the old word.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (biu_ext_w_strb[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= biu_ext_w_data[8*i +: 8];
                end
            end
        end
    end

    assign ext_biu_ar_ready = r_ar_ready;
    assign ext_biu_r_valid  = r_r_valid;
    assign ext_biu_r_id     = r_r_id;
    assign ext_biu_r_data   = r_r_data;
    assign ext_biu_r_resp   = r_r_resp;
    assign ext_biu_r_last   = r_r_last;
    assign ext_biu_aw_ready = r_aw_ready;
    assign ext_biu_w_ready  = r_w_ready;
    assign ext_biu_b_valid  = r_b_valid;
    assign ext_biu_b_id     = r_b_id;
    assign ext_biu_b_resp   = r_b_resp;

endmodule

// File: tb/tb_c7bbiu_axi_sram_slave.sv
// Scoreboard bench for c7bbiu_axi_sram_slave: directed AXI bursts, queued expectations, negedge monitor.
// Honours C7BBIU_AXI_SLV_ERR_EN for the out-of-window read case.
module tb_c7bbiu_axi_sram_slave;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        biu_ext_ar_valid = 1'b0;
    logic        ext_biu_ar_ready;
    logic [3:0]  biu_ext_ar_id = '0;
    logic [31:0] biu_ext_ar_addr = '0;
    logic [7:0]  biu_ext_ar_len = '0;
    logic        ext_biu_r_valid;
    logic        biu_ext_r_ready = 1'b1;
    logic [3:0]  ext_biu_r_id;
    logic [63:0] ext_biu_r_data;
    logic [1:0]  ext_biu_r_resp;
    logic        ext_biu_r_last;
    logic        biu_ext_aw_valid = 1'b0;
    logic        ext_biu_aw_ready;
    logic [3:0]  biu_ext_aw_id = '0;
    logic [31:0] biu_ext_aw_addr = '0;
    logic [7:0]  biu_ext_aw_len = '0;
    logic        biu_ext_w_valid = 1'b0;
    logic        ext_biu_w_ready;
    logic [63:0] biu_ext_w_data = '0;
    logic [7:0]  biu_ext_w_strb = '0;
    logic        biu_ext_w_last = 1'b0;
    logic        ext_biu_b_valid;
    logic        biu_ext_b_ready = 1'b0;
    logic [3:0]  ext_biu_b_id;
    logic [1:0]  ext_biu_b_resp;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  id;
        logic        last;
        logic [1:0]  resp;
    } rexp_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    int    n_checks = 0;
    int    n_err = 0;
    bit    last_done = 1'b0;

    c7bbiu_axi_sram_slave #(.MEM_AW(10), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .biu_ext_ar_valid(biu_ext_ar_valid), .ext_biu_ar_ready(ext_biu_ar_ready),
        .biu_ext_ar_id(biu_ext_ar_id), .biu_ext_ar_addr(biu_ext_ar_addr), .biu_ext_ar_len(biu_ext_ar_len),
        .ext_biu_r_valid(ext_biu_r_valid), .biu_ext_r_ready(biu_ext_r_ready),
        .ext_biu_r_id(ext_biu_r_id), .ext_biu_r_data(ext_biu_r_data),
        .ext_biu_r_resp(ext_biu_r_resp), .ext_biu_r_last(ext_biu_r_last),
        .biu_ext_aw_valid(biu_ext_aw_valid), .ext_biu_aw_ready(ext_biu_aw_ready),
        .biu_ext_aw_id(biu_ext_aw_id), .biu_ext_aw_addr(biu_ext_aw_addr), .biu_ext_aw_len(biu_ext_aw_len),
        .biu_ext_w_valid(biu_ext_w_valid), .ext_biu_w_ready(ext_biu_w_ready),
        .biu_ext_w_data(biu_ext_w_data), .biu_ext_w_strb(biu_ext_w_strb), .biu_ext_w_last(biu_ext_w_last),
        .ext_biu_b_valid(ext_biu_b_valid), .biu_ext_b_ready(biu_ext_b_ready),
        .ext_biu_b_id(ext_biu_b_id), .ext_biu_b_resp(ext_biu_b_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s actual=timeout/unexpected required=event", name);
    endtask

    // Monitor: compares presented R/B against queue heads, pops on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (last_done) begin
                check("ar_ready_after_last", 64'(ext_biu_ar_ready), 64'd1);
                last_done = 1'b0;
            end
            if (ext_biu_r_valid && rq.size() > 0) begin
                check("r_data", ext_biu_r_data, rq[0].data);
                check("r_id", 64'(ext_biu_r_id), 64'(rq[0].id));
                check("r_last", 64'(ext_biu_r_last), 64'(rq[0].last));
                check("r_resp", 64'(ext_biu_r_resp), 64'(rq[0].resp));
            end
            if (ext_biu_r_valid && biu_ext_r_ready) begin
                if (rq.size() == 0) begin
                    flag_fail("r_unexpected_beat");
                end else begin
                    if (rq[0].last) last_done = 1'b1;
                    void'(rq.pop_front());
                end
            end
            if (ext_biu_b_valid) begin
                check("aw_ready_during_b", 64'(ext_biu_aw_ready), 64'd0);
                if (bq.size() == 0) begin
                    flag_fail("b_unexpected");
                end else begin
                    check("b_id", 64'(ext_biu_b_id), 64'(bq[0].id));
                    check("b_resp", 64'(ext_biu_b_resp), 64'(bq[0].resp));
                    if (biu_ext_b_ready) void'(bq.pop_front());
                end
            end
        end
    end

    task automatic push_r(input logic [63:0] d, input logic [3:0] id, input logic last, input logic [1:0] resp);
        rexp_t e;
        e.data = d; e.id = id; e.last = last; e.resp = resp;
        rq.push_back(e);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 1'b0;
        biu_ext_ar_valid = 1'b1; biu_ext_ar_id = id; biu_ext_ar_addr = addr; biu_ext_ar_len = len;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk); ok = ext_biu_ar_ready;
            @(posedge clk); #1;
        end
        biu_ext_ar_valid = 1'b0;
        if (!ok) flag_fail("ar_handshake");
        @(negedge clk);
        check("r_valid_latency", 64'(ext_biu_r_valid), 64'd1);
    endtask

    task automatic drain_r(input bit toggle);
        for (int c = 0; c < 300 && rq.size() > 0; c++) begin
            biu_ext_r_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            @(posedge clk); #1;
        end
        biu_ext_r_ready = 1'b1;
        if (rq.size() > 0) flag_fail("r_drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [63:0] base, input logic [7:0] strb, input int hold);
        bit ok;
        bexp_t e;
        e.id = id; e.resp = 2'b00;
        bq.push_back(e);
        biu_ext_b_ready = (hold == 0);
        ok = 1'b0;
        biu_ext_aw_valid = 1'b1; biu_ext_aw_id = id; biu_ext_aw_addr = addr; biu_ext_aw_len = len;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk); ok = ext_biu_aw_ready;
            @(posedge clk); #1;
        end
        biu_ext_aw_valid = 1'b0;
        if (!ok) flag_fail("aw_handshake");
        for (int i = 0; i <= int'(len); i++) begin
            biu_ext_w_valid = 1'b1; biu_ext_w_data = base + 64'(i);
            biu_ext_w_strb = strb; biu_ext_w_last = (i == int'(len));
            ok = 1'b0;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk); ok = ext_biu_w_ready;
                @(posedge clk); #1;
            end
            if (!ok) flag_fail("w_handshake");
        end
        biu_ext_w_valid = 1'b0; biu_ext_w_last = 1'b0;
        @(negedge clk);
        check("b_valid_latency", 64'(ext_biu_b_valid), 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("b_valid_held", 64'(ext_biu_b_valid), 64'd1);
            check("aw_ready_held", 64'(ext_biu_aw_ready), 64'd0);
        end
        biu_ext_b_ready = 1'b1;
        for (int k = 0; k < 50 && bq.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        if (bq.size() > 0) flag_fail("b_drain");
        @(posedge clk); #1;
        biu_ext_b_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_ar_ready", 64'(ext_biu_ar_ready), 64'd1);
        check("rst_aw_ready", 64'(ext_biu_aw_ready), 64'd1);
        check("rst_r_valid", 64'(ext_biu_r_valid), 64'd0);
        check("rst_w_ready", 64'(ext_biu_w_ready), 64'd0);
        check("rst_b_valid", 64'(ext_biu_b_valid), 64'd0);
        check("rst_r_data", ext_biu_r_data, 64'd0);
        check("rst_r_last", 64'(ext_biu_r_last), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Known contents for word 0 and word 8.
        write_burst(4'h0, 32'h0, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
        write_burst(4'h0, 32'h40, 8'd0, 64'hDEAD_BEEF_0000_0040, 8'hFF, 0);

        push_r(64'hDEAD_BEEF_0000_0040, 4'h2, 1'b1, 2'b00);
        send_ar(4'h2, 32'h40, 8'd0);
        drain_r(1'b0);

        write_burst(4'h1, 32'h100, 8'd3, 64'hA0, 8'hFF, 0);
        for (int i = 0; i < 4; i++) push_r(64'hA0 + 64'(i), 4'h6, (i == 3), 2'b00);
        send_ar(4'h6, 32'h100, 8'd3);
        drain_r(1'b0);

        // Partial strobe with B stalled for three cycles.
        write_burst(4'h3, 32'h200, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        write_burst(4'h4, 32'h200, 8'd0, 64'h1111_2222_3333_4444, 8'h0F, 3);
        push_r(64'hFFFF_FFFF_3333_4444, 4'h5, 1'b1, 2'b00);
        send_ar(4'h5, 32'h200, 8'd0);
        drain_r(1'b0);

        // R backpressure pattern 1,0,0,1.
        biu_ext_r_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_r(64'hA0 + 64'(i), 4'h7, (i == 3), 2'b00);
        send_ar(4'h7, 32'h100, 8'd3);
        drain_r(1'b1);
        check("r_valid_after_burst", 64'(ext_biu_r_valid), 64'd0);

        // Reset in the middle of a read and a write burst.
        biu_ext_r_ready = 1'b0;
        push_r(64'hA0, 4'h3, 1'b0, 2'b00);
        push_r(64'hA1, 4'h3, 1'b0, 2'b00);
        send_ar(4'h3, 32'h100, 8'd7);
        @(posedge clk); #1;
        biu_ext_r_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        biu_ext_r_ready = 1'b0;
        check("mid_rd_queue_empty", 64'(rq.size()), 64'd0);
        biu_ext_aw_valid = 1'b1; biu_ext_aw_id = 4'h5; biu_ext_aw_addr = 32'h300; biu_ext_aw_len = 8'd3;
        @(posedge clk); #1;
        biu_ext_aw_valid = 1'b0;
        biu_ext_w_valid = 1'b1; biu_ext_w_data = 64'h55; biu_ext_w_strb = 8'hFF;
        @(posedge clk); #1;
        biu_ext_w_data = 64'h56;
        reset = 1'b1;
        biu_ext_w_valid = 1'b0;
        #1;
        check("mid_rst_r_valid", 64'(ext_biu_r_valid), 64'd0);
        check("mid_rst_b_valid", 64'(ext_biu_b_valid), 64'd0);
        check("mid_rst_ar_ready", 64'(ext_biu_ar_ready), 64'd1);
        check("mid_rst_aw_ready", 64'(ext_biu_aw_ready), 64'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        biu_ext_r_ready = 1'b1;
        @(posedge clk); #1;
        push_r(64'hA0, 4'h8, 1'b1, 2'b00);
        send_ar(4'h8, 32'h100, 8'd0);
        drain_r(1'b0);

        // Address one window past the memory.
`ifdef C7BBIU_AXI_SLV_ERR_EN
        push_r(64'd0, 4'h9, 1'b1, 2'b10);
`else
        push_r(64'h0123_4567_89AB_CDEF, 4'h9, 1'b1, 2'b00);
`endif
        send_ar(4'h9, 32'h2000, 8'd0);
        drain_r(1'b0);

        check("final_rq_empty", 64'(rq.size()), 64'd0);
        check("final_bq_empty", 64'(bq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/c7bbiu_axi_sram_slave.md
Name:
c7bbiu_axi_sram_slave

Overview:
- AXI slave (responder) backed by a 64-bit-wide register-array SRAM; the target-side counterpart of the BIU's AXI master port.
- Serves IFU/ICU/LSU read and LSU write bursts in system-level simulation and on FPGA bring-up.
- Independent read and write FSMs; one outstanding transaction per direction.

Parameters:
- MEM_AW, 10, word-address width; memory holds 2^MEM_AW 64-bit words, indexed by addr[MEM_AW+2:3].
- BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.

Ports:
- clk  in  1  clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- biu_ext_ar_valid  in  1  read address valid.
- ext_biu_ar_ready  out  1  read address ready.
- biu_ext_ar_id  in  4  read ID.
- biu_ext_ar_addr  in  32  read byte address.
- biu_ext_ar_len  in  8  beats minus 1.
- ext_biu_r_valid  out  1  read data valid.
- biu_ext_r_ready  in  1  read data ready.
- ext_biu_r_id  out  4  echoed AR ID.
- ext_biu_r_data  out  64  read data.
- ext_biu_r_resp  out  2  read response.
- ext_biu_r_last  out  1  final beat.
- biu_ext_aw_valid  in  1  write address valid.
- ext_biu_aw_ready  out  1  write address ready.
- biu_ext_aw_id  in  4  write ID.
- biu_ext_aw_addr  in  32  write byte address.
- biu_ext_aw_len  in  8  beats minus 1.
- biu_ext_w_valid  in  1  write data valid.
- ext_biu_w_ready  out  1  write data ready.
- biu_ext_w_data  in  64  write data.
- biu_ext_w_strb  in  8  byte enables.
- biu_ext_w_last  in  1  final beat (informational).
- ext_biu_b_valid  out  1  write response valid.
- biu_ext_b_ready  in  1  write response ready.
- ext_biu_b_id  out  4  echoed AW ID.
- ext_biu_b_resp  out  2  write response.

Behaviour:
- Transfer model: size fixed at 8 bytes, burst INCR only. The master's size, burst, lock, cache, prot and w_id are not connected. Address low 3 bits are ignored.
- Reset values:
  - ext_biu_ar_ready = 1, ext_biu_aw_ready = 1.
  - All other outputs = 0.
  - Memory contents are not reset.
- Reset mid-burst: both FSMs return to IDLE; the in-flight burst is dropped; no R or B beat is issued.
- Read FSM states RD_IDLE and RD_BURST:
  - RD_IDLE: ar_ready = 1. On an AR handshake, latch id, word address (addr − BASE_ADDR) >> 3, and len; clear the beat counter; go to RD_BURST.
  - Latency: AR handshake at cycle N gives r_valid = 1 at N+1.
  - RD_BURST: ar_ready = 0; r_data = mem[cur] (registered); r_last = (cnt == len); r_resp = 2'b00.
  - r_valid and all R fields hold stable while r_ready = 0.
  - On an R handshake: if last, go to RD_IDLE (ar_ready = 1 next cycle); otherwise cnt++, cur++, next word loaded, so one beat per cycle under continuous ready.
- Write FSM states WR_IDLE, WR_DATA, WR_RESP:
  - WR_IDLE: aw_ready = 1, w_ready = 0. W beats are never accepted before AW. On an AW handshake, latch id, word address and len; go to WR_DATA.
  - WR_DATA: w_ready = 1. On each W handshake, write every byte i of mem[cur] where strb[i] = 1, then cur++ and cnt++.
  - The burst ends on the beat where cnt == len; w_last is ignored for termination. Go to WR_RESP.
  - WR_RESP: b_valid = 1, b_id = latched id, b_resp = 2'b00. Hold until b_ready, then go to WR_IDLE.
- Address arithmetic: word address is MEM_AW bits and wraps modulo 2^MEM_AW, both on the burst increment and for out-of-range addresses. The 8-bit len supports up to 256 beats.
- Read/write collision: a write to the word being loaded into r_data in the same cycle gives old data on R. The new data is visible to later loads.
- Read and write channels operate concurrently and independently.

Optional Feature:
- Macro: C7BBIU_AXI_SLV_ERR_EN.
- When defined:
  - Any beat whose byte address is outside [BASE_ADDR, BASE_ADDR + 8·2^MEM_AW) returns r_resp = 2'b10 with r_data = 0.
  - Writes to such beats are suppressed.
  - A write burst containing any such beat, or whose w_last disagrees with (cnt == len), gets b_resp = 2'b10.
- When undefined: addresses wrap modulo memory size, and all responses are 2'b00.

Test Plan:
- Reset, then AR id 4'h2, addr 0x40, len 0 → r_valid one cycle after the handshake, r_data = mem[8], r_last = 1, r_id = 2, ar_ready = 1 the following cycle.
- AW id 4'h1, addr 0x100, len 3, four W beats 0xA0..0xA3, strb 8'hFF → b_valid one cycle after the 4th beat, b_id = 1. Then AR addr 0x100 len 3 returns A0..A3 on consecutive cycles with r_last on beat 3 only.
- Write strb 8'h0F with data 0x1111_2222_3333_4444 over a word holding 0xFFFF_FFFF_FFFF_FFFF → read returns 0xFFFF_FFFF_3333_4444.
- Read burst len 3 with r_ready toggling 1,0,0,1,… → each beat's data, id and last held stable across stalls; exactly 4 beats; b_ready held 0 during a write keeps b_valid = 1 and aw_ready = 0.
- Assert reset during beat 2 of a len 7 read and beat 1 of a len 3 write → r_valid = 0, b_valid = 0, ar_ready = 1, aw_ready = 1 immediately; the next AR is served normally.
- With C7BBIU_AXI_SLV_ERR_EN, MEM_AW = 10, read addr 0x2000 → r_resp = 2'b10, r_data = 0. Without the macro, the same read returns mem[0] with r_resp = 2'b00.
